// File: rtl/alsu_gen_if.sv
// Operand/modifier inputs and result/status outputs of alsu_gen, grouped as one bus.
// The master drives operations; the slave (alsu_gen) returns results and error status.
interface alsu_gen_if #(
    parameter int unsigned WIDTH = 3
) ();
    logic                      valid_in;
    logic [2:0]                opcode;
    logic signed [WIDTH-1:0]   A;
    logic signed [WIDTH-1:0]   B;
    logic                      cin;
    logic                      serial_in;
    logic                      direction;
    logic                      red_op_A;
    logic                      red_op_B;
    logic                      bypass_A;
    logic                      bypass_B;
    logic signed [2*WIDTH-1:0] out;
    logic                      valid_out;
    logic [15:0]               leds;
    logic [7:0]                invalid_count;

    modport master (
        output valid_in, opcode, A, B, cin, serial_in, direction,
        output red_op_A, red_op_B, bypass_A, bypass_B,
        input  out, valid_out, leds, invalid_count
    );

    modport slave (
        input  valid_in, opcode, A, B, cin, serial_in, direction,
        input  red_op_A, red_op_B, bypass_A, bypass_B,
        output out, valid_out, leds, invalid_count
    );
endinterface

// File: rtl/alsu_gen.sv
// Two-stage pipelined ALSU: stage 1 captures qualified inputs, stage 2 computes the
// 2*WIDTH result and runs the error FSM (blinking leds) and saturating invalid counter.
module alsu_gen #(
    parameter int unsigned WIDTH          = 3,
    parameter string       INPUT_PRIORITY = "A",
    parameter string       FULL_ADDER     = "ON",
    parameter int unsigned BLINK_DIV      = 1
) (
    input logic       clk,
    input logic       rst,
    alsu_gen_if.slave bus
);
    localparam int unsigned OW         = 2 * WIDTH;
    localparam bit          PRIO_A     = (INPUT_PRIORITY == "A");
    localparam bit          FA_ON      = (FULL_ADDER == "ON");
    localparam int unsigned CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);

    localparam logic [2:0] OpOr     = 3'd0;
    localparam logic [2:0] OpXor    = 3'd1;
    localparam logic [2:0] OpAdd    = 3'd2;
    localparam logic [2:0] OpMult   = 3'd3;
    localparam logic [2:0] OpShift  = 3'd4;
    localparam logic [2:0] OpRotate = 3'd5;

    typedef enum logic {StOk, StErr} state_e;

    // Stage 1
    logic             v1_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q, ser_q, dir_q, red_a_q, red_b_q, byp_a_q, byp_b_q;

    // Stage 2
    logic [OW-1:0] out_q, out_d;
    logic          valid_out_q;
    state_e        state_q, state_d;
    logic [15:0]   leds_q, leds_d;
    logic [CW-1:0] blink_q, blink_d;
    logic [7:0]    inv_cnt_q, inv_cnt_d;

    logic [OW-1:0]    a_ext, b_ext, op_res, res;
    logic [WIDTH-1:0] red_src;
    logic             reduce, invalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            ser_q       <= 1'b0;
            dir_q       <= 1'b0;
            red_a_q     <= 1'b0;
            red_b_q     <= 1'b0;
            byp_a_q     <= 1'b0;
            byp_b_q     <= 1'b0;
            out_q       <= '0;
            valid_out_q <= 1'b0;
            state_q     <= StOk;
            leds_q      <= '0;
            blink_q     <= '0;
            inv_cnt_q   <= '0;
        end else begin
            v1_q <= bus.valid_in;
            if (bus.valid_in) begin
                op_q    <= bus.opcode;
                a_q     <= bus.A;
                b_q     <= bus.B;
                cin_q   <= bus.cin;
                ser_q   <= bus.serial_in;
                dir_q   <= bus.direction;
                red_a_q <= bus.red_op_A;
                red_b_q <= bus.red_op_B;
                byp_a_q <= bus.bypass_A;
                byp_b_q <= bus.bypass_B;
            end
            out_q       <= out_d;
            valid_out_q <= v1_q;
            state_q     <= state_d;
            leds_q      <= leds_d;
            blink_q     <= blink_d;
            inv_cnt_q   <= inv_cnt_d;
        end
    end

    always_comb begin
        a_ext   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        b_ext   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        reduce  = red_a_q | red_b_q;
        red_src = (red_a_q && red_b_q) ? (PRIO_A ? a_q : b_q) : (red_a_q ? a_q : b_q);
        invalid = (op_q[2:1] == 2'b11) || (reduce && (op_q != OpOr) && (op_q != OpXor));

        op_res = '0;
        case (op_q)
            OpOr:     op_res = reduce ? {{(OW-1){1'b0}}, |red_src} : (a_ext | b_ext);
            OpXor:    op_res = reduce ? {{(OW-1){1'b0}}, ^red_src} : (a_ext ^ b_ext);
            OpAdd:    op_res = a_ext + b_ext + {{(OW-1){1'b0}}, cin_q & FA_ON};
            // Low OW bits of the product of sign-extended operands equal the signed product.
            OpMult:   op_res = a_ext * b_ext;
            OpShift:  op_res = dir_q ? {out_q[OW-2:0], ser_q} : {ser_q, out_q[OW-1:1]};
            OpRotate: op_res = dir_q ? {out_q[OW-2:0], out_q[OW-1]} : {out_q[0], out_q[OW-1:1]};
            default:  op_res = '0;
        endcase

        if (byp_a_q && byp_b_q) res = PRIO_A ? a_ext : b_ext;
        else if (byp_a_q)       res = a_ext;
        else if (byp_b_q)       res = b_ext;
        else if (invalid)       res = '0;
        else                    res = op_res;

        out_d = v1_q ? res : out_q;
    end

    always_comb begin
        state_d   = state_q;
        leds_d    = leds_q;
        blink_d   = blink_q;
        inv_cnt_d = inv_cnt_q;

        case (state_q)
            StOk: begin
                if (v1_q && invalid) begin
                    state_d = StErr;
                    leds_d  = 16'hFFFF;
                    blink_d = '0;
                end
            end
            StErr: begin
                if (v1_q && !invalid) begin
                    state_d = StOk;
                    leds_d  = '0;
                    blink_d = '0;
                end else if (blink_q == BLINK_LAST) begin
                    // A repeated invalid op keeps the running blink phase.
                    blink_d = '0;
                    leds_d  = ~leds_q;
                end else begin
                    blink_d = blink_q + CW'(1);
                end
            end
            default: state_d = StOk;
        endcase

        if (v1_q && invalid && (inv_cnt_q != 8'hFF)) inv_cnt_d = inv_cnt_q + 8'd1;
    end

    assign bus.out           = out_q;
    assign bus.valid_out     = valid_out_q;
    assign bus.leds          = leds_q;
    assign bus.invalid_count = inv_cnt_q;
endmodule

// File: tb/tb_alsu_gen.sv
// Directed bench: two alsu_gen instances (priority A / full adder / blink 2 and
// priority B / half adder / blink 1) share one stimulus stream.
module tb_alsu_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alsu_gen_if #(.WIDTH(3)) bus_a ();
    alsu_gen_if #(.WIDTH(3)) bus_b ();

    assign bus_b.valid_in  = bus_a.valid_in;
    assign bus_b.opcode    = bus_a.opcode;
    assign bus_b.A         = bus_a.A;
    assign bus_b.B         = bus_a.B;
    assign bus_b.cin       = bus_a.cin;
    assign bus_b.serial_in = bus_a.serial_in;
    assign bus_b.direction = bus_a.direction;
    assign bus_b.red_op_A  = bus_a.red_op_A;
    assign bus_b.red_op_B  = bus_a.red_op_B;
    assign bus_b.bypass_A  = bus_a.bypass_A;
    assign bus_b.bypass_B  = bus_a.bypass_B;

    alsu_gen #(.WIDTH(3), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .BLINK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    alsu_gen #(.WIDTH(3), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"), .BLINK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    task automatic drive(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                         input logic c, input logic s, input logic d, input logic ra,
                         input logic rb, input logic ba, input logic bb);
        bus_a.valid_in  = 1'b1;
        bus_a.opcode    = op;
        bus_a.A         = a;
        bus_a.B         = b;
        bus_a.cin       = c;
        bus_a.serial_in = s;
        bus_a.direction = d;
        bus_a.red_op_A  = ra;
        bus_a.red_op_B  = rb;
        bus_a.bypass_A  = ba;
        bus_a.bypass_B  = bb;
    endtask

    task automatic idle();
        bus_a.valid_in = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        vectors++; if (bus_a.out !== 6'd0) begin miscompares++;
            $display("FAIL reset_out_a got=%b want=000000", bus_a.out); end
        vectors++; if (bus_b.valid_out !== 1'b0) begin miscompares++;
            $display("FAIL reset_valid_b got=%b want=0", bus_b.valid_out); end
        vectors++; if (bus_a.leds !== 16'h0) begin miscompares++;
            $display("FAIL reset_leds_a got=%h want=0000", bus_a.leds); end
        vectors++; if (bus_b.invalid_count !== 8'd0) begin miscompares++;
            $display("FAIL reset_cnt_b got=%0d want=0", bus_b.invalid_count); end
        rst = 1'b0;
        idle();
        step();
    endtask

    task automatic test_add();
        drive(3'd2, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (bus_a.valid_out !== 1'b0) begin miscompares++;
            $display("FAIL add_latency_valid got=%b want=0", bus_a.valid_out); end
        idle();
        step();
        vectors++; if (bus_a.out !== 6'd6) begin miscompares++;
            $display("FAIL add_full_a got=%b want=000110", bus_a.out); end
        vectors++; if (bus_b.out !== 6'd5) begin miscompares++;
            $display("FAIL add_half_b got=%b want=000101", bus_b.out); end
        vectors++; if (bus_a.valid_out !== 1'b1) begin miscompares++;
            $display("FAIL add_valid_pulse got=%b want=1", bus_a.valid_out); end
        step();
        vectors++; if (bus_a.valid_out !== 1'b0 || bus_a.out !== 6'd6) begin miscompares++;
            $display("FAIL add_bubble_hold got=%b/%b want=0/000110", bus_a.valid_out, bus_a.out); end
        drive(3'd2, 3'b100, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        vectors++; if (bus_a.out !== 6'b111001) begin miscompares++;
            $display("FAIL add_neg_full_a got=%b want=111001", bus_a.out); end
        vectors++; if (bus_b.out !== 6'b111000) begin miscompares++;
            $display("FAIL add_neg_half_b got=%b want=111000", bus_b.out); end
    endtask

    task automatic test_mult();
        drive(3'd3, 3'b100, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        vectors++; if (bus_a.out !== 6'b110100) begin miscompares++;
            $display("FAIL mult_a got=%b want=110100", bus_a.out); end
        vectors++; if (bus_b.out !== 6'b110100) begin miscompares++;
            $display("FAIL mult_b got=%b want=110100", bus_b.out); end
    endtask

    task automatic test_back_to_back();
        drive(3'd2, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(3'd4, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (bus_a.out !== 6'b000110) begin miscompares++;
            $display("FAIL b2b_load got=%b want=000110", bus_a.out); end
        drive(3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (bus_a.out !== 6'b001101) begin miscompares++;
            $display("FAIL b2b_shift_left got=%b want=001101", bus_a.out); end
        idle();
        step();
        vectors++; if (bus_b.out !== 6'b100110 || bus_b.valid_out !== 1'b1) begin miscompares++;
            $display("FAIL b2b_rotate_right got=%b/%b want=100110/1", bus_b.out, bus_b.valid_out); end
        step();
    endtask

    task automatic test_reduction();
        drive(3'd0, 3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(3'd1, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (bus_a.out !== 6'd0) begin miscompares++;
            $display("FAIL red_or_prio_a got=%b want=000000", bus_a.out); end
        vectors++; if (bus_b.out !== 6'd1) begin miscompares++;
            $display("FAIL red_or_prio_b got=%b want=000001", bus_b.out); end
        drive(3'd1, 3'b101, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        vectors++; if (bus_a.out !== 6'd1) begin miscompares++;
            $display("FAIL red_xor_a got=%b want=000001", bus_a.out); end
        idle();
        step();
        vectors++; if (bus_b.out !== 6'b111110) begin miscompares++;
            $display("FAIL xor_bitwise got=%b want=111110", bus_b.out); end
        vectors++; if (bus_a.leds !== 16'h0) begin miscompares++;
            $display("FAIL red_no_error got=%h want=0000", bus_a.leds); end
    endtask

    task automatic test_error_blink();
        drive(3'd6, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        vectors++; if (bus_a.out !== 6'd0 || bus_a.leds !== 16'hFFFF) begin miscompares++;
            $display("FAIL err_enter got=%b/%h want=000000/ffff", bus_a.out, bus_a.leds); end
        vectors++; if (bus_a.invalid_count !== 8'd1) begin miscompares++;
            $display("FAIL err_count got=%0d want=1", bus_a.invalid_count); end
        step();
        vectors++; if (bus_a.leds !== 16'hFFFF || bus_b.leds !== 16'h0000) begin miscompares++;
            $display("FAIL blink_e1 got=%h/%h want=ffff/0000", bus_a.leds, bus_b.leds); end
        step();
        vectors++; if (bus_a.leds !== 16'h0000 || bus_b.leds !== 16'hFFFF) begin miscompares++;
            $display("FAIL blink_e2 got=%h/%h want=0000/ffff", bus_a.leds, bus_b.leds); end
        step();
        step();
        vectors++; if (bus_a.leds !== 16'hFFFF) begin miscompares++;
            $display("FAIL blink_e4 got=%h want=ffff", bus_a.leds); end
        drive(3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        idle();
        step();
        vectors++; if (bus_a.out !== 6'd3 || bus_a.leds !== 16'h0) begin miscompares++;
            $display("FAIL err_clear_a got=%b/%h want=000011/0000", bus_a.out, bus_a.leds); end
        step();
        vectors++; if (bus_b.leds !== 16'h0) begin miscompares++;
            $display("FAIL err_clear_b got=%h want=0000", bus_b.leds); end
    endtask

    task automatic test_bypass();
        drive(3'd0, 3'b110, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        drive(3'd2, 3'b110, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        vectors++; if (bus_a.out !== 6'b111110) begin miscompares++;
            $display("FAIL bypass_prio_a got=%b want=111110", bus_a.out); end
        vectors++; if (bus_b.out !== 6'b000001) begin miscompares++;
            $display("FAIL bypass_prio_b got=%b want=000001", bus_b.out); end
        drive(3'd1, 3'b001, 3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        vectors++; if (bus_a.out !== 6'b111110 || bus_a.leds !== 16'hFFFF) begin miscompares++;
            $display("FAIL bypass_invalid_a got=%b/%h want=111110/ffff", bus_a.out, bus_a.leds); end
        vectors++; if (bus_b.invalid_count !== 8'd2) begin miscompares++;
            $display("FAIL bypass_invalid_cnt got=%0d want=2", bus_b.invalid_count); end
        idle();
        step();
        vectors++; if (bus_a.out !== 6'b111101 || bus_a.leds !== 16'h0) begin miscompares++;
            $display("FAIL bypass_b_only got=%b/%h want=111101/0000", bus_a.out, bus_a.leds); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            drive(3'd7, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        idle();
        step();
        vectors++; if (bus_a.invalid_count !== 8'd255) begin miscompares++;
            $display("FAIL sat_cnt_a got=%0d want=255", bus_a.invalid_count); end
        vectors++; if (bus_b.invalid_count !== 8'd255) begin miscompares++;
            $display("FAIL sat_cnt_b got=%0d want=255", bus_b.invalid_count); end
    endtask

    task automatic test_reset_midflight();
        drive(3'd2, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        vectors++; if (bus_a.out !== 6'd2 || bus_a.valid_out !== 1'b1) begin miscompares++;
            $display("FAIL burst_pre got=%b/%b want=000010/1", bus_a.out, bus_a.valid_out); end
        rst = 1'b1;
        step();
        vectors++; if (bus_a.out !== 6'd0 || bus_a.valid_out !== 1'b0) begin miscompares++;
            $display("FAIL rst_mid_a got=%b/%b want=000000/0", bus_a.out, bus_a.valid_out); end
        vectors++; if (bus_b.invalid_count !== 8'd0 || bus_b.leds !== 16'h0) begin miscompares++;
            $display("FAIL rst_mid_b got=%0d/%h want=0/0000", bus_b.invalid_count, bus_b.leds); end
        rst = 1'b0;
        idle();
        step();
        vectors++; if (bus_a.valid_out !== 1'b0 || bus_b.valid_out !== 1'b0) begin miscompares++;
            $display("FAIL rst_inflight got=%b/%b want=0/0", bus_a.valid_out, bus_b.valid_out); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_back_to_back();
        test_reduction();
        test_error_blink();
        test_bypass();
        test_saturate();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alsu_gen.md
# alsu_gen

Parametrised, pipelined successor of the 3-bit ALSU. It performs logic, arithmetic, reduction, shift and rotate operations on signed WIDTH-bit operands and produces a 2·WIDTH-bit signed result. It adds a valid handshake, an error state machine with a programmable LED blink rate, and a saturating invalid-operation counter. It sits on the same datapath position as the ALSU and is driven by a register-slice master.

## Interface
- WIDTH, 3: operand width in bits (2..16); result width OW = 2·WIDTH.
- INPUT_PRIORITY, "A": operand selected ("A" or "B") when both bypass flags or both reduction flags are set.
- FULL_ADDER, "ON": "ON" means ADD includes cin; "OFF" means cin is ignored.
- BLINK_DIV, 1: number of clock cycles between LED toggles while in ERR (≥1).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- valid_in  in  1  input qualifier; all inputs below are sampled only when it is 1.
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 INVALID.
- A, B  in  WIDTH  signed operands.
- cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B  in  1 each  operation modifiers; direction=1 means left.
- out  out  OW  signed result register.
- valid_out  out  1  one-cycle pulse marking an updated out.
- leds  out  16  error indicator.
- invalid_count  out  8  saturating count of invalid operations.

## Operation
- Stage 1: when valid_in=1, register all inputs and set v1=1. Otherwise set v1=0 and keep the held inputs.
- Stage 2: when v1=1, compute from the stage-1 registers and update out, valid_out, the FSM and invalid_count. When v1=0, out holds its value and valid_out=0.
- invalid = (opcode∈{6,7}) OR ((red_op_A|red_op_B) AND opcode∉{OR,XOR}).
- out priority, highest first:
  - Both bypass flags set: the priority operand.
  - bypass_A alone: A.
  - bypass_B alone: B.
  - invalid: 0.
  - Otherwise, the opcode result.
- All operands are sign-extended to OW.
- OR/XOR:
  - Both reduction flags set: reduction (|x or ^x) of the priority operand.
  - One reduction flag set: reduction of that operand.
  - No reduction flag: bitwise A op B.
  - Reduction results are zero-extended 1-bit values.
- ADD: A+B(+cin when FULL_ADDER="ON"), signed, computed in OW bits with no overflow possible.
- MULT: signed A·B, full OW bits.
- SHIFT: operates on the current out. direction=1 gives {out[OW-2:0],serial_in}; direction=0 gives {serial_in,out[OW-1:1]}.
- ROTATE: operates on the current out. direction=1 gives {out[OW-2:0],out[OW-1]}; direction=0 gives {out[0],out[OW-1:1]}.
- Bypass does not mask error detection. invalid still drives the FSM and the counter even when out is bypassed.
- Error FSM, states OK and ERR:
  - OK→ERR on an accepted invalid op: leds←16'hFFFF, blink counter←0.
  - In ERR, leds invert every BLINK_DIV cycles, whether or not v1 is set.
  - ERR→OK on an accepted valid op: leds←0.
  - ERR with another invalid op stays in ERR; the blink phase is not reset.
- invalid_count increments on each accepted invalid op and saturates at 255.

## Timing
- Reset values: out=0, valid_out=0, leds=0, invalid_count=0, v1=0, FSM=OK, blink counter=0.
- rst mid-operation discards both stages. No valid_out is produced for ops in flight.
- Latency is 2 cycles. Inputs sampled at edge k appear on out and valid_out at edge k+1.
- Full throughput: back-to-back valid_in gives back-to-back valid_out.
- Back-to-back SHIFT/ROTATE each act on the out value written at the previous edge.
- valid_in=0 bubbles propagate as valid_out=0. out holds, and leds keep blinking in ERR.
- BLINK_DIV=1 toggles leds every cycle in ERR, matching the legacy ALSU.

## Test plan
- Reset, then ADD with A=3, B=2, cin=1 (WIDTH=3, FULL_ADDER="ON") -> 2 cycles later out=6'd6 with valid_out pulsed for 1 cycle.
- MULT with A=-4, B=3 -> out=6'b110100 (-12). With FULL_ADDER="OFF", ADD with A=-4, B=-4, cin=1 -> out=-8.
- Load out=6'b000110, then SHIFT dir=1 serial_in=1 -> 6'b001101. Next cycle ROTATE dir=0 -> 6'b100110.
- opcode=6 with BLINK_DIV=2 -> out=0, leds=FFFF, invalid_count=1. leds then read 0000 two cycles later and FFFF two cycles after that. A following valid OR (A=1, B=2) -> out=3, leds=0.
- bypass_A=bypass_B=1 with A=-2, B=1 and INPUT_PRIORITY="A" -> out=6'b111110. Adding red_op_A=1 with opcode=ADD -> out is still -2, FSM enters ERR, and the counter increments.
- 300 consecutive invalid ops -> invalid_count=255. Assert rst during a valid_in burst -> no valid_out for in-flight ops, and all outputs are 0 on the next cycle.
